ex_mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute-stage ALU. Captures the ALU result with its instruction context, resolves branch/jump outcomes into a one-cycle redirect, computes load/store addresses and link values, and presents a registered, valid/ready packet to the memory stage. A two-entry skid buffer makes `ex_ready` independent of same-cycle `mem_ready`.

---
 rtl/cpu_pkg.sv | 84 ++++++++
 rtl/ex_mem_stage_if.sv | 37 +++
 rtl/skid_fifo2.sv | 78 +++++++
 rtl/ex_mem_stage.sv | 82 ++++++++
 tb/tb_ex_mem_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op codes, the EX->MEM packet and packet formation.
package cpu_pkg;

    localparam int DATA_W = 64;

    localparam logic [7:0] OP_ADD      = 8'd0;
    localparam logic [7:0] OP_ALU_LAST = 8'd42;
    localparam logic [7:0] OP_SB       = 8'd43;
    localparam logic [7:0] OP_SH       = 8'd44;
    localparam logic [7:0] OP_SW       = 8'd45;
    localparam logic [7:0] OP_SD       = 8'd46;
    localparam logic [7:0] OP_BEQ      = 8'd47;
    localparam logic [7:0] OP_BNE      = 8'd48;
    localparam logic [7:0] OP_BLT      = 8'd49;
    localparam logic [7:0] OP_BGE      = 8'd50;
    localparam logic [7:0] OP_BLTU     = 8'd51;
    localparam logic [7:0] OP_BGEU     = 8'd52;
    localparam logic [7:0] OP_JAL      = 8'd53;
    localparam logic [7:0] OP_JALR     = 8'd54;
    localparam logic [7:0] OP_LUI      = 8'd55;
    localparam logic [7:0] OP_AUIPC    = 8'd56;
    localparam logic [7:0] OP_ECALL    = 8'd57;
    localparam logic [7:0] OP_EBREAK   = 8'd58;
    localparam logic [7:0] OP_LB       = 8'd59;
    localparam logic [7:0] OP_LH       = 8'd60;
    localparam logic [7:0] OP_LW       = 8'd61;
    localparam logic [7:0] OP_LBU      = 8'd62;
    localparam logic [7:0] OP_LHU      = 8'd63;
    localparam logic [7:0] OP_LWU      = 8'd64;
    localparam logic [7:0] OP_LD       = 8'd65;

    typedef struct packed {
        logic [7:0]        instruction;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] result;
        logic [4:0]        rd;
        logic              reg_write;
    } ex_mem_pkt_t;

    localparam int PKT_W = $bits(ex_mem_pkt_t);

    function automatic logic is_load(input logic [7:0] op);
        return (op >= OP_LB) && (op <= OP_LD);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    function automatic logic is_branch(input logic [7:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    // Builds the MEM packet; fields an op does not use stay zero.
    function automatic ex_mem_pkt_t form_pkt(
        input logic [7:0]        op,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] rs1,
        input logic [DATA_W-1:0] rs2,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] pc,
        input logic [4:0]        rd
    );
        ex_mem_pkt_t p;
        p             = '0;
        p.instruction = op;
        p.rd          = rd;
        if (op <= OP_ALU_LAST) p.result = alu;
        if (is_load(op) || is_store(op)) p.addr = rs1 + imm;
        if (is_store(op)) p.wdata = rs2;
        case (op)
            OP_JAL, OP_JALR: p.result = pc + DATA_W'(4);
            OP_LUI:          p.result = imm;
            OP_AUIPC:        p.result = pc + imm;
            default: ;
        endcase
        // ECALL/EBREAK, stores and branches never write back.
        p.reg_write = (rd != 5'd0) &&
                      ((op <= OP_ALU_LAST) || ((op >= OP_JAL) && (op <= OP_AUIPC)) || is_load(op));
        return p;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> stage -> MEM bundle. The stage uses the slave view; the driver side uses master.
interface ex_mem_stage_if #(parameter int XLEN = 64);
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [7:0]      ex_instruction;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            mem_valid;
    logic            mem_ready;
    logic [7:0]      mem_instruction;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  flush, ex_valid, ex_instruction, ex_alu_result, ex_rs1, ex_rs2,
               ex_imm, ex_pc, ex_rd, mem_ready,
        output ex_ready, mem_valid, mem_instruction, mem_addr, mem_wdata,
               mem_result, mem_rd, mem_reg_write, redirect_valid, redirect_pc
    );

    modport master (
        output flush, ex_valid, ex_instruction, ex_alu_result, ex_rs1, ex_rs2,
               ex_imm, ex_pc, ex_rd, mem_ready,
        input  ex_ready, mem_valid, mem_instruction, mem_addr, mem_wdata,
               mem_result, mem_rd, mem_reg_write, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO. Input ready comes from a register, so it never sees out_ready.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] e0_q, e0_d;     // head (older entry)
    logic [W-1:0] e1_q, e1_d;
    logic         rdy_q;
    logic         push, pop;

    assign push = in_valid_i && rdy_q;
    assign pop  = (state_q != EMPTY) && out_ready_i;

    // Next state and entry updates; the head only moves on a pop or a push into an empty buffer.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    e0_d    = in_data_i;
                    state_d = ONE;
                end
                ONE: begin
                    if (push && pop) begin
                        e0_d = in_data_i;
                    end else if (push) begin
                        e1_d    = in_data_i;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (pop) begin
                    e0_d    = e1_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register; ready is precomputed from the next state so it is a plain flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = e0_q;
    assign count_o     = (state_q == TWO) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: forms the MEM packet, raises a one-cycle redirect for taken
// branches and jumps, and buffers packets in a two-entry skid FIFO.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);
    if (DEPTH != 2 || XLEN != DATA_W) begin : g_bad_param
        $error("ex_mem_stage supports only DEPTH=2 and XLEN=%0d", DATA_W);
    end

    localparam logic [XLEN-1:0] LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};

    ex_mem_pkt_t     pkt_d, head;
    logic            fifo_rdy, fifo_vld;
    logic [1:0]      fifo_cnt;
    logic            accept, taken;
    logic            redir_q, redir_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    assign accept = bus.ex_valid && fifo_rdy;
    assign pkt_d  = form_pkt(bus.ex_instruction, bus.ex_alu_result, bus.ex_rs1,
                             bus.ex_rs2, bus.ex_imm, bus.ex_pc, bus.ex_rd);

    // Redirect decision; a packet arriving during a redirect is younger and is dropped.
    always_comb begin
        taken      = 1'b0;
        redir_pc_d = bus.ex_pc + bus.ex_imm;
        if (is_branch(bus.ex_instruction)) begin
            taken = bus.ex_alu_result[0];
        end else if (bus.ex_instruction == OP_JAL) begin
            taken = 1'b1;
        end else if (bus.ex_instruction == OP_JALR) begin
            taken      = 1'b1;
            redir_pc_d = (bus.ex_rs1 + bus.ex_imm) & LSB_CLR;
        end
        redir_d = accept && !redir_q && !bus.flush && taken;
    end

    // Redirect pulse register; the target holds its last value between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            redir_q <= redir_d;
            if (redir_d) redir_pc_q <= redir_pc_d;
        end
    end

    skid_fifo2 #(.W(PKT_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.flush),
        .in_valid_i (bus.ex_valid && !redir_q),
        .in_ready_o (fifo_rdy),
        .in_data_i  (pkt_d),
        .out_valid_o(fifo_vld),
        .out_ready_i(bus.mem_ready),
        .out_data_o (head),
        .count_o    (fifo_cnt)
    );

    assign bus.ex_ready        = fifo_rdy;
    assign bus.mem_valid       = fifo_vld;
    assign bus.mem_instruction = head.instruction;
    assign bus.mem_addr        = head.addr;
    assign bus.mem_wdata       = head.wdata;
    assign bus.mem_result      = head.result;
    assign bus.mem_rd          = head.rd;
    assign bus.mem_reg_write   = head.reg_write;
    assign bus.redirect_valid  = redir_q;
    assign bus.redirect_pc     = redir_pc_q;

    a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
        (fifo_cnt == 2'd2) |-> !fifo_rdy);
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed packets with hand-computed expectations.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.XLEN(64)) bus();
    ex_mem_stage #(.XLEN(64), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    ex_mem_pkt_t exp_q[$];
    logic [63:0] rq[$];
    ex_mem_pkt_t mon_e;
    logic [63:0] mon_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic ex_mem_pkt_t mk(input logic [7:0] op, input logic [63:0] addr,
        input logic [63:0] wdata, input logic [63:0] result, input logic [4:0] rd, input logic rw);
        ex_mem_pkt_t p;
        p.instruction = op; p.addr = addr; p.wdata = wdata;
        p.result = result; p.rd = rd; p.reg_write = rw;
        return p;
    endfunction

    // Monitor: compares every MEM handshake and every redirect pulse against the queues.
    always @(negedge clk) begin
        if (!reset && bus.mem_valid && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pkt: got op %0d result %h, expected no packet",
                         bus.mem_instruction, bus.mem_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("mem_instruction", 64'(bus.mem_instruction), 64'(mon_e.instruction));
                check("mem_addr", bus.mem_addr, mon_e.addr);
                check("mem_wdata", bus.mem_wdata, mon_e.wdata);
                check("mem_result", bus.mem_result, mon_e.result);
                check("mem_rd", 64'(bus.mem_rd), 64'(mon_e.rd));
                check("mem_reg_write", 64'(bus.mem_reg_write), 64'(mon_e.reg_write));
            end
        end
        if (!reset && bus.redirect_valid) begin
            if (rq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_redirect: got pc %h, expected no redirect", bus.redirect_pc);
            end else begin
                mon_pc = rq.pop_front();
                check("redirect_pc", bus.redirect_pc, mon_pc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one EX packet and returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] op, input logic [63:0] alu, input logic [63:0] rs1,
        input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] pc,
        input logic [4:0] rd, input bit fl);
        int n;
        bus.ex_valid = 1'b1; bus.ex_instruction = op; bus.ex_alu_result = alu;
        bus.ex_rs1 = rs1; bus.ex_rs2 = rs2; bus.ex_imm = imm; bus.ex_pc = pc;
        bus.ex_rd = rd; bus.flush = fl;
        n = 0;
        @(negedge clk);
        while (!bus.ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ex_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: ex_ready got 0, expected 1");
        end
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        bus.flush = 0; bus.ex_valid = 0; bus.ex_instruction = 0; bus.ex_alu_result = 0;
        bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_imm = 0; bus.ex_pc = 0; bus.ex_rd = 0;
        bus.mem_ready = 1;

        // Reset state
        idle(2);
        check("rst_mem_valid", 64'(bus.mem_valid), 0);
        check("rst_ex_ready", 64'(bus.ex_ready), 0);
        check("rst_redirect_valid", 64'(bus.redirect_valid), 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check("rst_mem_result", bus.mem_result, 0);
        check("rst_mem_reg_write", 64'(bus.mem_reg_write), 0);
        reset = 0;
        idle(1);
        check("post_rst_ex_ready", 64'(bus.ex_ready), 1);
        check("post_rst_mem_valid", 64'(bus.mem_valid), 0);

        // ALU results and rd=0 suppression
        exp_q.push_back(mk(OP_ADD, 0, 0, 64'h5, 5'd3, 1'b1));
        send(OP_ADD, 64'h5, 64'h1, 64'h2, 0, 64'h100, 5'd3, 0);
        check("add_latency_valid", 64'(bus.mem_valid), 1);
        exp_q.push_back(mk(OP_ADD, 0, 0, 64'h7, 5'd0, 1'b0));
        send(OP_ADD, 64'h7, 0, 0, 0, 64'h104, 5'd0, 0);
        idle(2);

        // Taken BEQ with a younger ADD in the redirect cycle
        exp_q.push_back(mk(OP_BEQ, 0, 0, 0, 5'd0, 1'b0));
        rq.push_back(64'h1020);
        send(OP_BEQ, 64'h1, 0, 0, 64'h20, 64'h1000, 5'd0, 0);
        check("beq_redirect_valid", 64'(bus.redirect_valid), 1);
        check("beq_redirect_pc_now", bus.redirect_pc, 64'h1020);
        send(OP_ADD, 64'h99, 0, 0, 0, 64'h1004, 5'd5, 0);
        check("redirect_one_cycle", 64'(bus.redirect_valid), 0);
        idle(1);

        // Not-taken BEQ
        exp_q.push_back(mk(OP_BEQ, 0, 0, 0, 5'd0, 1'b0));
        send(OP_BEQ, 64'h0, 0, 0, 64'h20, 64'h2000, 5'd0, 0);
        check("beq_nt_no_redirect", 64'(bus.redirect_valid), 0);
        idle(1);

        // JALR clears bit 0, JAL with negative offset
        exp_q.push_back(mk(OP_JALR, 0, 0, 64'h404, 5'd1, 1'b1));
        rq.push_back(64'h2002);
        send(OP_JALR, 0, 64'h2003, 0, 0, 64'h400, 5'd1, 0);
        idle(1);
        exp_q.push_back(mk(OP_JAL, 0, 0, 64'h3004, 5'd1, 1'b1));
        rq.push_back(64'h2FF8);
        send(OP_JAL, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3000, 5'd1, 0);
        idle(1);

        // AUIPC wrap, LUI, ECALL
        exp_q.push_back(mk(OP_AUIPC, 0, 0, 64'h10, 5'd6, 1'b1));
        send(OP_AUIPC, 0, 0, 0, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 5'd6, 0);
        exp_q.push_back(mk(OP_LUI, 0, 0, 64'h1234_5000, 5'd7, 1'b1));
        send(OP_LUI, 64'hAB, 0, 0, 64'h1234_5000, 0, 5'd7, 0);
        exp_q.push_back(mk(OP_ECALL, 0, 0, 0, 5'd4, 1'b0));
        send(OP_ECALL, 0, 0, 0, 0, 64'h500, 5'd4, 0);
        idle(2);

        // Backpressure: SW then LD fill the buffer
        bus.mem_ready = 0;
        exp_q.push_back(mk(OP_SW, 64'h108, 64'hDEAD, 0, 5'd0, 1'b0));
        send(OP_SW, 64'h55, 64'h100, 64'hDEAD, 64'h8, 64'h600, 5'd0, 0);
        exp_q.push_back(mk(OP_LD, 64'h1F0, 0, 0, 5'd7, 1'b1));
        send(OP_LD, 64'h77, 64'h200, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h604, 5'd7, 0);
        check("two_ex_ready", 64'(bus.ex_ready), 0);
        check("two_mem_valid", 64'(bus.mem_valid), 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("stall_addr", bus.mem_addr, 64'h108);
            check("stall_wdata", bus.mem_wdata, 64'hDEAD);
        end
        bus.mem_ready = 1;
        #1;
        check("ready_no_comb_path", 64'(bus.ex_ready), 0);
        idle(3);

        // Flush in state ONE together with a push
        bus.mem_ready = 0;
        send(OP_ADD, 64'h11, 0, 0, 0, 64'h700, 5'd2, 0);
        check("flush_pre_valid", 64'(bus.mem_valid), 1);
        send(OP_ADD, 64'h22, 0, 0, 0, 64'h704, 5'd2, 1);
        check("flush_mem_valid", 64'(bus.mem_valid), 0);
        check("flush_ex_ready", 64'(bus.ex_ready), 1);
        bus.mem_ready = 1;
        idle(2);
        send(OP_JAL, 0, 0, 0, 64'h40, 64'h800, 5'd1, 1);
        check("flush_cancels_redirect", 64'(bus.redirect_valid), 0);
        idle(2);

        // Asynchronous reset with two entries buffered
        bus.mem_ready = 0;
        send(OP_ADD, 64'h1, 0, 0, 0, 64'h900, 5'd1, 0);
        send(OP_ADD, 64'h2, 0, 0, 0, 64'h904, 5'd2, 0);
        check("pre_rst_ex_ready", 64'(bus.ex_ready), 0);
        #2 reset = 1;
        #1;
        check("async_rst_mem_valid", 64'(bus.mem_valid), 0);
        check("async_rst_mem_result", bus.mem_result, 0);
        @(posedge clk);
        #1 reset = 0;
        bus.mem_ready = 1;
        idle(1);
        check("rel_ex_ready", 64'(bus.ex_ready), 1);
        check("rel_mem_valid", 64'(bus.mem_valid), 0);
        exp_q.push_back(mk(OP_ADD, 0, 0, 64'hA5, 5'd9, 1'b1));
        send(OP_ADD, 64'hA5, 0, 0, 0, 64'hA00, 5'd9, 0);
        idle(3);

        check("pkt_queue_drained", 64'(exp_q.size()), 0);
        check("redirect_queue_drained", 64'(rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
